// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: a DEPTH-entry circular FIFO
// with registered storage, no bypass, and a flush that discards all entries.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = `ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [AW-1:0]                in_pc,
  input  logic [31:0]                  in_instr,
  input  logic                         in_guesses_branch,
  input  logic [AW-1:0]                in_prediction,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [AW-1:0]                out_pc,
  output logic [31:0]                  out_instr,
  output logic                         out_guesses_branch,
  output logic [AW-1:0]                out_prediction,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   instr;
    logic          guesses_branch;
    logic [AW-1:0] prediction;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop;

  // Readiness depends only on occupancy, so a full queue never passes through.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign out_pc             = mem[head].pc;
  assign out_instr          = mem[head].instr;
  assign out_guesses_branch = mem[head].guesses_branch;
  assign out_prediction     = mem[head].prediction;

  // Pointers are PW bits wide and DEPTH is a power of two, so +1 wraps to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: storage is reset too, so out_* read zero while the queue is empty after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // NOTE: non-blocking assignments let push and pop read the pre-edge pointers and count.
      if (push) begin
        mem[tail] <= entry_t'{pc: in_pc, instr: in_instr,
                              guesses_branch: in_guesses_branch,
                              prediction: in_prediction};
        tail      <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; power of two, >= 2.
REQ-002 Parameter AW, default `ADDR_WIDTH, PC and prediction width.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  driver: branch feedback (if_branch && !if_prediction_correct); discard all entries.
REQ-006 in_valid  input  1  fetch entry offered.
REQ-007 in_pc  input  AW  fetched PC.
REQ-008 in_instr  input  32  fetched instruction word.
REQ-009 in_guesses_branch  input  1  predictor guessed taken branch.
REQ-010 in_prediction  input  AW  predicted next PC.
REQ-011 in_ready  output  1  queue accepts an entry this cycle.
REQ-012 out_valid  output  1  head entry presented to decode.
REQ-013 out_pc / out_instr / out_guesses_branch / out_prediction  output  AW/32/1/AW  head entry fields.
REQ-014 out_ready  input  1  decode consumes head this cycle.
REQ-015 count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 Storage: circular buffer of DEPTH entries {pc, instr, guesses_branch, prediction}; head pointer, tail pointer, occupancy counter.
REQ-017 Push = in_valid && in_ready && !flush; entry written at tail, tail advances by 1.
REQ-018 Pop = out_valid && out_ready && !flush; head advances by 1.
REQ-019 Pointers wrap DEPTH-1 -> 0.
REQ-020 in_ready = (count != DEPTH); no dependence on out_ready (no pass-through when full).
REQ-021 out_valid = (count != 0); out_* fields driven combinationally from entry[head].
REQ-022 No bypass: entry pushed in cycle N is first visible on out_* in cycle N+1 (latency 1).
REQ-023 Push and pop in the same cycle: both take effect, count unchanged.
REQ-024 Count: +1 on push only, -1 on pop only, else held; never exceeds DEPTH, never underflows.
REQ-025 Empty: out_valid=0, out_ready ignored, no pointer change.
REQ-026 Full: in_ready=0, in_valid ignored, entry contents preserved.
REQ-027 Flush: next cycle head=0, tail=0, count=0; same-cycle push and pop discarded; flush has priority over all other events.
REQ-028 Flush while empty or repeated flush: no effect beyond REQ-027.
REQ-029 Entry order strictly FIFO; fields of an entry never mixed with another entry.
REQ-030 Stalled head (out_valid=1, out_ready=0): out_* held stable until popped or flushed.

Reset
REQ-031 rst asserted: head=0, tail=0, count=0 immediately, independent of clk.
REQ-032 During reset: out_valid=0, in_ready=1, count=0; storage entries cleared to 0 so out_* read 0.
REQ-033 Reset mid-operation: all in-flight entries lost; no push accepted while rst=1; normal operation from first clk edge after deassertion.

Verification
REQ-034 Fill: DEPTH=8, out_ready=0, push pc 0x100..0x11C step 4 -> count=8, in_ready=0 after 8th push; 9th offer not stored.
REQ-035 Drain: then out_ready=1, in_valid=0 -> out_pc 0x100..0x11C in order over 8 cycles, then out_valid=0, count=0.
REQ-036 Simultaneous: count=3, push and pop each cycle for 20 cycles -> count stays 3, order preserved across pointer wrap.
REQ-037 Flush: count=5, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; flushed PCs never appear; subsequent push pc 0x200 emerges first.
REQ-038 Latency: empty queue, push pc 0x40 in cycle N -> out_valid=0 in N, out_valid=1 with out_pc=0x40 in N+1.
REQ-039 Async reset: count=4, assert rst between clock edges -> out_valid=0, count=0, in_ready=1 before next edge; after release first push appears as head.
